// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Purpose  : Stall/bubble/flush sequencing for the 5-stage integer pipeline:
//            load-use interlock, taken-branch squash, multi-cycle EX handshake.
// Revision : 1.0  initial release
// ============================================================================
module hazard_stall_controller #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             memread_ex,
    input  logic             mc_op_ex,
    input  logic             branch_taken_ex,
    input  logic             mc_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             mc_start,
    output logic             mc_busy,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int c_wd_w = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(MC_TIMEOUT - 1);

    localparam logic [0:0] c_st_run     = 1'b0;
    localparam logic [0:0] c_st_mc_wait = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_wd_w-1:0] r_wait_cnt;
    logic              r_mc_timeout;
    logic [CNT_W-1:0]  r_stall_count;

    logic w_load_use;
    logic w_wd_expire;
    logic w_release;

    // rd_ex == 0 targets x0, which is never really written, so it never interlocks.
    assign w_load_use = memread_ex && (rd_ex != 5'd0) &&
                        ((uses_rs1_id && (rs1_id == rd_ex)) ||
                         (uses_rs2_id && (rs2_id == rd_ex)));

    assign w_wd_expire = (r_state == c_st_mc_wait) && !mc_done && (r_wait_cnt == c_wd_last);
    assign w_release   = (r_state == c_st_mc_wait) && (mc_done || (r_wait_cnt == c_wd_last));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (!branch_taken_ex && mc_op_ex) begin
                    w_state_nxt = c_st_mc_wait;
                end
            end
            c_st_mc_wait: begin
                if (w_release) begin
                    w_state_nxt = c_st_run;
                end
            end
            default: w_state_nxt = c_st_run;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        mc_start     = 1'b0;
        mc_busy      = 1'b0;
        if (!reset) begin
            case (r_state)
                c_st_run: begin
                    if (branch_taken_ex) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (mc_op_ex) begin
                        mc_start     = 1'b1;
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end else if (w_load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                c_st_mc_wait: begin
                    // The release cycle still reports busy; the EX op advances on this edge.
                    mc_busy = 1'b1;
                    if (!w_release) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- watchdog, error flag and stall counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_mc_timeout  <= 1'b0;
            r_stall_count <= '0;
        end else begin
            if ((r_state == c_st_mc_wait) && !w_release) begin
                r_wait_cnt <= r_wait_cnt + c_wd_w'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_wd_expire) begin
                r_mc_timeout <= 1'b1;
            end
            if (!pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign mc_timeout  = r_mc_timeout;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
